// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, baud/byte-count derivations and byte FSM state encoding.
package uart_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    function automatic int baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    function automatic int byte_count(input int data_width);
        return (data_width + 7) / 8;
    endfunction
endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line in, frame payload and status pulses out.
interface uart_rx_frame_if #(parameter int DATA_WIDTH = 120);
    logic                  rx;
    logic [DATA_WIDTH-1:0] po_data;
    logic                  po_flag;
    logic                  frame_err;
    modport master (output rx, input po_data, po_flag, frame_err);
    modport slave  (input rx, output po_data, po_flag, frame_err);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: rx synchronizer, baud counter and 8N1 byte FSM; byte_valid_o/byte_err_o pulse
// in the stop-bit sample cycle.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int UART_BPS = 115200,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       byte_err_o,
    output logic       idle_o
);
    localparam int BAUD = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int CW   = $clog2(BAUD + 1);

    logic          rx_s1_q, rx_s2_q, rx_d_q;
    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_d_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            rx_d_q  <= rx_s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        byte_err_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = (rx_d_q && !rx_s2_q) ? ST_START : ST_IDLE;
            end
            // mid-bit check rejects glitches shorter than half a bit
            ST_START: if (cnt_q == CW'(BAUD / 2)) begin
                cnt_d   = '0;
                state_d = rx_s2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (cnt_q == CW'(BAUD - 1)) begin
                cnt_d   = '0;
                shift_d = {rx_s2_q, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? ST_STOP : ST_DATA;
            end
            ST_STOP: if (cnt_q == CW'(BAUD - 1)) begin
                state_d      = ST_IDLE;
                byte_valid_o = rx_s2_q;
                byte_err_o   = !rx_s2_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_o = shift_q;
    assign idle_o = state_q == ST_IDLE;
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: assembles BYTE_COUNT received bytes into a payload with inter-byte timeout.
// Define UART_RX_CHECKSUM_EN to require a trailing mod-256 sum byte per frame.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int UART_BPS          = 115200,
    parameter int CLK_FREQ          = 50_000_000,
    parameter int DATA_WIDTH        = 120,
    parameter int IDLE_TIMEOUT_BITS = 20
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    uart_rx_frame_if.slave bus
);
    localparam int BC = byte_count(DATA_WIDTH);
`ifdef UART_RX_CHECKSUM_EN
    localparam int LAST = BC;
`else
    localparam int LAST = BC - 1;
`endif
    localparam int CW = $clog2(LAST + 2);
    localparam int TO = IDLE_TIMEOUT_BITS * baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int TW = $clog2(TO + 1);

    logic [7:0]            rx_byte;
    logic                  byte_valid, byte_err, idle, last, timeout, good, bad;
    logic [8*BC-1:0]       frame_q, frame_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         to_q, to_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  flag_q, err_q;
`ifdef UART_RX_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    uart_rx_byte #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) u_byte (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx_i         (bus.rx),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .byte_err_o   (byte_err),
        .idle_o       (idle)
    );

    always_comb begin
        frame_d = frame_q;
        for (int k = 0; k < BC; k++)
            if (byte_valid && cnt_q == CW'(k)) frame_d[8*k +: 8] = rx_byte;
        last    = cnt_q == CW'(LAST);
        timeout = idle && cnt_q != '0 && to_q == TW'(TO - 1);
        to_d    = (idle && cnt_q != '0 && !timeout) ? to_q + 1'b1 : '0;
`ifdef UART_RX_CHECKSUM_EN
        good  = byte_valid && last && rx_byte == sum_q;
        bad   = byte_err || timeout || (byte_valid && last && rx_byte != sum_q);
        sum_d = (good || bad) ? '0 : byte_valid ? sum_q + rx_byte : sum_q;
`else
        good  = byte_valid && last;
        bad   = byte_err || timeout;
`endif
        cnt_d  = (good || bad) ? '0 : byte_valid ? cnt_q + 1'b1 : cnt_q;
        data_d = good ? frame_d[DATA_WIDTH-1:0] : data_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_q <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            data_q  <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_RX_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            data_q  <= data_d;
            flag_q  <= good;
            err_q   <= bad;
`ifdef UART_RX_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign bus.po_data   = data_q;
    assign bus.po_flag   = flag_q;
    assign bus.frame_err = err_q;
endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 The block SHALL have parameter UART_BPS, default 115200, serial bit rate.
REQ-002 The block SHALL have parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 120, payload width in bits (any value >= 1).
REQ-004 The block SHALL have parameter IDLE_TIMEOUT_BITS, default 20, inter-byte timeout in bit times.
REQ-005 sys_clk  input  1  clock; all logic on rising edge.
REQ-006 sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-007 rx  input  1  asynchronous serial line; idle high.
REQ-008 po_data  output  DATA_WIDTH  last good frame payload.
REQ-009 po_flag  output  1  one-cycle pulse; po_data is new.
REQ-010 frame_err  output  1  one-cycle pulse; frame discarded.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; one further register SHALL be used for falling-edge detection.
REQ-012 Derived constants: BAUD_CNT_MAX = CLK_FREQ/UART_BPS; BYTE_COUNT = ceil(DATA_WIDTH/8).
REQ-013 Line format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-014 Byte FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on synchronized falling edge; baud counter cleared.
REQ-016 In START, the line SHALL be sampled at baud count BAUD_CNT_MAX/2: if 0 -> DATA; if 1 -> false start, back to IDLE, no error.
REQ-017 DATA SHALL sample 8 bits, each one full BAUD_CNT_MAX after the previous sample, then go to STOP.
REQ-018 In STOP, one sample: if 1, byte accepted; if 0, framing error. Either case -> IDLE.
REQ-019 Byte k of the frame (k = 0 first) SHALL be stored in payload bits [8k+7:8k]; bits above DATA_WIDTH-1 in the final byte are discarded.
REQ-020 After the stop-bit sample of byte BYTE_COUNT-1, the block SHALL update po_data and pulse po_flag on the next cycle. po_data SHALL then hold until the next good frame.
REQ-021 On a framing error, the block SHALL discard the partial frame, reset the byte counter to 0, pulse frame_err, and leave po_data unchanged.
REQ-022 Inter-byte timeout: if byte counter != 0 and IDLE persists for IDLE_TIMEOUT_BITS*BAUD_CNT_MAX cycles, the block SHALL discard the partial frame, reset the byte counter, and pulse frame_err.
REQ-023 po_flag and frame_err SHALL never be asserted in the same cycle.
REQ-024 The byte counter SHALL wrap to 0 after each completed or discarded frame.

Reset
REQ-025 On reset, po_data SHALL be 0, po_flag 0, frame_err 0, FSM in IDLE, and all counters 0. Synchronizer flops SHALL reset to 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame silently, with no pulse on either flag.

Configuration
REQ-027 Macro UART_RX_CHECKSUM_EN defined: each frame SHALL carry one extra trailing byte equal to the sum mod 256 of the BYTE_COUNT payload bytes. On match: po_flag. On mismatch: frame_err, po_data unchanged.
REQ-028 Macro undefined: no checksum byte; a frame is exactly BYTE_COUNT bytes.

Structure
REQ-029 Shared package uart_pkg SHALL hold the BAUD_CNT_MAX/BYTE_COUNT derivation functions and the FSM state encodings, shared with the TX pump.
REQ-030 Sub-module uart_rx_byte SHALL contain the synchronizer, baud counter and byte FSM. Its outputs: 8-bit byte, byte_valid pulse, byte_err pulse. Frame assembly, timeout and checksum stay in uart_rx_frame.

Verification
REQ-031 Bench with DATA_WIDTH=16, no checksum: send 0x34 then 0x12 -> po_data=0x1234, po_flag one pulse, frame_err 0.
REQ-032 Default DATA_WIDTH=120: send bytes 0x00..0x0E -> po_data=0x0E0D...0100, exactly one po_flag.
REQ-033 Byte 1 of a 2-byte frame with stop bit forced 0 -> frame_err pulse, po_data keeps prior value. The next clean frame 0xAA,0x55 -> 0x55AA.
REQ-034 Glitch on rx: low for BAUD_CNT_MAX/4 cycles -> no byte, no flags.
REQ-035 Send 1 byte, then idle for 21 bit times -> frame_err pulse. The next 2-byte frame is received correctly.
REQ-036 UART_RX_CHECKSUM_EN, DATA_WIDTH=16: 0x34,0x12,0x46 -> po_flag. 0x34,0x12,0x47 -> frame_err.
